// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bundle: instruction memory port, redirect request, output stream
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_misaligned;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_misaligned,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_misaligned,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-entry instruction fetch stage with redirect and misaligned-target trap
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic            clk,
  input logic            rst,
  fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {RUN, TRAP_PEND, TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        mis_q, mis_d;
  logic [31:0] count_q, count_d;
  logic        fire;
  logic        free;

  assign fire = valid_q & bus.out_ready;
  assign free = ~valid_q | fire;

  assign bus.imem_addr      = pc_q;
  assign bus.out_valid      = valid_q;
  assign bus.out_instr      = instr_q;
  assign bus.out_pc         = opc_q;
  assign bus.out_misaligned = mis_q;
  assign bus.fetch_count    = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      opc_q   <= 32'h0;
      mis_q   <= 1'b0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      mis_q   <= mis_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    mis_d   = mis_q;
    count_d = count_q;

    // A fire retires the entry even when a redirect lands in the same cycle.
    if (fire) begin
      valid_d = 1'b0;
      count_d = count_q + 32'd1;
    end

    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
      state_d = (bus.redirect_pc[1:0] == 2'b00) ? RUN : TRAP_PEND;
    end else begin
      case (state_q)
        RUN: begin
          if (free) begin
            instr_d = bus.imem_rdata;
            opc_d   = pc_q;
            mis_d   = 1'b0;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
        TRAP_PEND: begin
          if (free) begin
            instr_d = NOP_INSTR;
            opc_d   = pc_q;
            mis_d   = 1'b1;
            valid_d = 1'b1;
            state_d = TRAP;
          end
        end
        default: begin
          // TRAP: parked until a redirect; the last entry drains normally.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a fire-stream scoreboard
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] WRAP_PC = 32'hFFFFFFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst2;

  fetch_stage_if bus();
  fetch_stage_if bus2();

  fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
  fetch_stage #(.RESET_PC(WRAP_PC)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  logic [31:0] mem [0:63];
  assign bus.imem_rdata  = mem[bus.imem_addr[7:2]];
  assign bus2.imem_rdata = mem[bus2.imem_addr[7:2]];

  int total = 0;
  int bad = 0;
  int fires = 0;

  // Scoreboard: the address the next fire must carry, whether it is a trap entry,
  // and whether the stage should be parked with nothing to offer.
  logic [31:0] exp_addr;
  logic        exp_trap;
  logic        exp_dead;
  logic [31:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst) begin
      exp_addr = 32'h0;
      exp_trap = 1'b0;
      exp_dead = 1'b0;
      exp_cnt  = 32'h0;
    end else begin
      chk("fetch_count", bus.fetch_count, exp_cnt);
      if (exp_dead) chk("trap_idle_valid", {31'b0, bus.out_valid}, 32'h0);
      if (bus.out_valid && bus.out_ready) begin
        fires++;
        chk("fire_pc", bus.out_pc, exp_addr);
        chk("fire_instr", bus.out_instr, exp_trap ? NOP : mem[exp_addr[7:2]]);
        chk("fire_misaligned", {31'b0, bus.out_misaligned}, {31'b0, exp_trap});
        if (exp_trap) exp_dead = 1'b1;
        else exp_addr = exp_addr + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
      end
      if (bus.redirect_valid) begin
        exp_addr = bus.redirect_pc;
        exp_trap = (bus.redirect_pc[1:0] != 2'b00);
        exp_dead = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst = 1'b1;
    rst2 = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus2.out_ready = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = 32'h0;
    tick();
    tick();

    chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_instr", bus.out_instr, NOP);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_mis", {31'b0, bus.out_misaligned}, 32'h0);
    chk("rst_count", bus.fetch_count, 32'h0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst2_imem_addr", bus2.imem_addr, WRAP_PC);

    // Streaming with the wrap instance running alongside.
    rst = 1'b0;
    rst2 = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_valid", {31'b0, bus.out_valid}, 32'h1);
      chk("stream_pc", bus.out_pc, 32'(4 * i));
      chk("stream_instr", bus.out_instr, mem[i]);
      if (i < 3) chk("wrap_pc", bus2.out_pc, WRAP_PC + 32'(4 * i));
    end
    tick();
    chk("stream_count4", bus.fetch_count, 32'd4);

    // Reset mid-stream drops the held entry and the counter.
    rst = 1'b1;
    tick();
    chk("midrst_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("midrst_count", bus.fetch_count, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("bp_pre_pc", bus.out_pc, 32'd4);

    // Backpressure holds the entry and the PC.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", {31'b0, bus.out_valid}, 32'h1);
      chk("bp_pc", bus.out_pc, 32'd4);
      chk("bp_instr", bus.out_instr, mem[1]);
      chk("bp_imem_addr", bus.imem_addr, 32'd8);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_pc", bus.out_pc, 32'd8);
    chk("bp_release_count", bus.fetch_count, 32'd2);
    tick();
    tick();
    chk("redir_pre_pc", bus.out_pc, 32'd16);

    // Aligned redirect coinciding with a fire.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd24;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_valid_e", {31'b0, bus.out_valid}, 32'h0);
    chk("redir_count", bus.fetch_count, 32'd5);
    chk("redir_imem_addr", bus.imem_addr, 32'd24);
    tick();
    chk("redir_valid_e1", {31'b0, bus.out_valid}, 32'h1);
    chk("redir_pc_e1", bus.out_pc, 32'd24);
    chk("redir_instr_e1", bus.out_instr, mem[6]);

    // Misaligned redirect: one trap entry, then parked.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h00000022;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("mis_valid_e", {31'b0, bus.out_valid}, 32'h0);
    tick();
    chk("trap_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("trap_mis", {31'b0, bus.out_misaligned}, 32'h1);
    chk("trap_instr", bus.out_instr, NOP);
    chk("trap_pc", bus.out_pc, 32'h22);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("trap_parked_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("trap_parked_addr", bus.imem_addr, 32'h22);
    end

    // Recovery from the parked state.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    chk("recover_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("recover_pc", bus.out_pc, 32'h0);
    chk("recover_instr", bus.out_instr, mem[0]);
    chk("recover_mis", {31'b0, bus.out_misaligned}, 32'h0);

    // Randomized traffic; every fire is checked by the scoreboard inside tick().
    fires = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      bus.redirect_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 3) == 0) bus.redirect_pc[1:0] = 2'($urandom_range(1, 3));
      tick();
    end
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    chk("random_fires_seen", {31'b0, (fires > 100)}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
